// File: rtl/key_debounce_repeat.sv
// Per-channel key conditioner: 2-FF synchronizer, debounce FSM, press/release pulses and
// optional auto-repeat while a key is held.
module key_debounce_repeat #(
  parameter int unsigned NUM_KEYS     = 7,
  parameter int unsigned DEBOUNCE_CNT = 2000,
  parameter int unsigned REPEAT_DELAY = 50000,
  parameter int unsigned REPEAT_RATE  = 10000,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_raw,
  input  logic [NUM_KEYS-1:0] repeat_en,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release
);

  localparam logic [CNT_W-1:0] DbLast    = CNT_W'(DEBOUNCE_CNT - 1);
  localparam logic [CNT_W-1:0] DelayLast = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RateLast  = CNT_W'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    StUp,
    StDnChk,
    StDown,
    StUpChk
  } state_e;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    state_e           state_q, state_d;
    logic [1:0]       sync_q;
    logic [CNT_W-1:0] dcnt_q, dcnt_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic             rpt_q, rpt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             rel_q, rel_d;
    logic             sync;

    assign sync = sync_q[1];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q <= StUp;
        sync_q  <= '0;
        dcnt_q  <= '0;
        hold_q  <= '0;
        rpt_q   <= 1'b0;
        level_q <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        sync_q  <= {sync_q[0], key_raw[i]};
        dcnt_q  <= dcnt_d;
        hold_q  <= hold_d;
        rpt_q   <= rpt_d;
        level_q <= level_d;
        press_q <= press_d;
        rel_q   <= rel_d;
      end
    end

    always_comb begin
      state_d = state_q;
      dcnt_d  = dcnt_q;
      hold_d  = hold_q;
      rpt_d   = rpt_q;
      level_d = level_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
      unique case (state_q)
        StUp: begin
          if (sync) begin
            state_d = StDnChk;
            dcnt_d  = '0;
          end
        end
        StDnChk: begin
          if (!sync) begin
            state_d = StUp;
          end else if (dcnt_q == DbLast) begin
            state_d = StDown;
            dcnt_d  = '0;
            level_d = 1'b1;
            press_d = 1'b1;
            hold_d  = '0;
            rpt_d   = 1'b0;
          end else begin
            dcnt_d = dcnt_q + 1'b1;
          end
        end
        StDown: begin
          // hold/rpt stay frozen across a release check so a bounce resumes the repeat phase
          if (!sync) begin
            state_d = StUpChk;
            dcnt_d  = '0;
          end else if (repeat_en[i]) begin
            if (hold_q == (rpt_q ? RateLast : DelayLast)) begin
              press_d = 1'b1;
              hold_d  = '0;
              rpt_d   = 1'b1;
            end else begin
              hold_d = hold_q + 1'b1;
            end
          end else begin
            hold_d = '0;
            rpt_d  = 1'b0;
          end
        end
        StUpChk: begin
          if (sync) begin
            state_d = StDown;
          end else if (dcnt_q == DbLast) begin
            state_d = StUp;
            dcnt_d  = '0;
            level_d = 1'b0;
            rel_d   = 1'b1;
          end else begin
            dcnt_d = dcnt_q + 1'b1;
          end
        end
        default: state_d = StUp;
      endcase
    end

    assign key_level[i]   = level_q;
    assign key_press[i]   = press_q;
    assign key_release[i] = rel_q;
  end

endmodule
